// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side uses master; the controller uses slave.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_is_load;
    logic [REG_W-1:0] ex_rd;
    logic             br_taken;
    logic             mem_busy;
    logic             cnt_clr;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       state;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_is_load, ex_rd, br_taken, mem_busy, cnt_clr,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        input  ifid_flush, idex_flush, state, mem_err,
        input  stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_is_load, ex_rd, br_taken, mem_busy, cnt_clr,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
        output ifid_flush, idex_flush, state, mem_err,
        output stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stall, branch flush,
// data-memory wait with timeout, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int unsigned      WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_e;

    state_e            state_q, state_d, state_eff;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic             rs1_hit, rs2_hit, load_use;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush;
    logic             br_flush;

    assign id_rs1 = hz.id_rs1;
    assign id_rs2 = hz.id_rs2;
    assign ex_rd  = hz.ex_rd;

    assign rs1_hit  = hz.id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = hz.id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = hz.ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

    // While reset is asserted the enables behave as if already in RUN.
    assign state_eff = reset ? RUN : state_q;

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        br_flush   = 1'b0;
        if (state_eff == ERR || hz.mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (hz.br_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            br_flush   = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        unique case (state_q)
            RUN: begin
                if (hz.mem_busy) begin
                    state_d    = MEMWAIT;
                    wait_cnt_d = WAIT_W'(1);
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEMWAIT: begin
                if (hz.mem_busy) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    if (wait_cnt_q == WAIT_LAST) state_d = ERR;
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            ERR: begin
                state_d = ERR;
                if (!hz.mem_busy) wait_cnt_d = '0;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (hz.cnt_clr) begin
            stall_d = '0;
            flush_d = '0;
        end else begin
            if (!pc_en && stall_q != CNT_MAX) stall_d = stall_q + CNT_W'(1);
            if (br_flush && flush_q != CNT_MAX) flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.idex_en      = idex_en;
    assign hz.exmem_en     = exmem_en;
    assign hz.memwb_en     = memwb_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_flush   = idex_flush;
    assign hz.state        = state_q;
    assign hz.mem_err      = (state_q == ERR);
    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;

endmodule
